tetris_soc_mem_arbiter: RTL
===========================

TETRIS_SOC_MEM_ARBITER -- requirements
Module: tetris_soc_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL be the word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width; byteenable width SHALL be DATA_W/8.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 mN_address (N=0,1)  input  ADDR_W  SHALL be the master N word address.
REQ-006 mN_byteenable  input  DATA_W/8  SHALL be the master N byte lanes.
REQ-007 mN_read, mN_write  input  1 each  SHALL be the master N command strobes.
REQ-008 mN_writedata  input  DATA_W  SHALL be the master N write data.
REQ-009 mN_waitrequest  output  1  SHALL be low only in the cycle the master N command is accepted.
REQ-010 mN_readdata  output  DATA_W  SHALL be the registered read return to master N.
REQ-011 mN_readdatavalid  output  1  SHALL be a one-cycle pulse qualifying mN_readdata.
REQ-012 mem_address, mem_byteenable, mem_writedata  outputs  ADDR_W, DATA_W/8, DATA_W  SHALL be the RAM command fields.
REQ-013 mem_chipselect, mem_write, mem_clken  outputs  1 each  SHALL be the RAM strobes; mem_clken SHALL be tied high.
REQ-014 mem_readdata  input  DATA_W  SHALL be the RAM read data, valid the cycle after the address is clocked.

Function
REQ-015 FSM states SHALL be IDLE and RD_WAIT; commands SHALL be accepted only in IDLE.
REQ-016 A master requests when mN_read or mN_write is high; read+write together SHALL be treated as a write only.
REQ-017 In IDLE, with one requester, it SHALL be granted; with both, the master not equal to last_grant SHALL be granted.
REQ-018 last_grant SHALL update to the accepted master on every acceptance; otherwise it SHALL hold.
REQ-019 On acceptance, mem_chipselect SHALL be 1, mem_write SHALL equal the write decision, and mem_address/byteenable/writedata SHALL carry the granted master's fields, combinationally in the same cycle.
REQ-020 In non-accept cycles, mem_chipselect and mem_write SHALL be 0 and the other mem_* fields SHALL be 0.
REQ-021 An accepted write SHALL complete in the acceptance cycle; FSM SHALL remain in IDLE.
REQ-022 An accepted read SHALL move the FSM to RD_WAIT and register the owner.
REQ-023 In RD_WAIT, the FSM SHALL capture mem_readdata into the owner's mN_readdata, pulse the owner's mN_readdatavalid in the next cycle, and return to IDLE.
REQ-024 Read latency SHALL be 2 cycles, from acceptance to the readdatavalid cycle; a new command MAY be accepted in the readdatavalid cycle.
REQ-025 In RD_WAIT, both mN_waitrequest SHALL be high, and requests SHALL be held off without loss.
REQ-026 mN_readdata SHALL hold its last value until that master's next read return.
REQ-027 A master holding its request continuously SHALL be served within 2 acceptance slots (no starvation).

Reset
REQ-028 On reset, the FSM SHALL go to IDLE, last_grant SHALL be 1 (so master 0 wins first contention), mN_readdata SHALL be 0, and mN_readdatavalid SHALL be 0.
REQ-029 During reset, mN_waitrequest SHALL be 1, mem_chipselect/mem_write SHALL be 0, and mem_clken SHALL be 1.
REQ-030 Reset asserted in RD_WAIT SHALL abort the read with no readdatavalid pulse after release.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RD_WAIT), NUM_MASTERS=2, and default ADDR_W/DATA_W constants.
REQ-032 The grant logic SHALL be one sub-module, tetris_rr_arbiter2, with inputs req[1:0] and last_grant and output grant[1:0].

Verification
REQ-033 m0 write addr 1, data 0xDEADBEEF, be 0xF, then m0 read addr 1 -> m0_readdatavalid 2 cycles after read acceptance, with m0_readdata=0xDEADBEEF.
REQ-034 Both masters read in the same cycle after reset -> m0 is granted first and m1 is accepted in m0's readdatavalid cycle; m1_waitrequest stays high meanwhile.
REQ-035 Both masters hold writes for 6 cycles -> acceptances alternate m0, m1, m0, ...; no master is accepted twice in a row.
REQ-036 m1 write addr 2, be 0x3, data 0x0000ABCD, over 0x11223344 -> a read of addr 2 returns 0x1122ABCD.
REQ-037 Reset asserted in RD_WAIT for a m1 read -> no m1_readdatavalid pulse after release, and m1_readdata=0.
REQ-038 m0 read and write both high, addr 3, data 0x5 -> a write occurs, no readdatavalid pulse, and a later read returns 0x5.

Source files
------------

// File: rtl/tetris_soc_mem_arbiter_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package tetris_soc_mem_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned DEF_ADDR_W  = 2;
  localparam int unsigned DEF_DATA_W  = 32;

  // IDLE accepts commands; RD_WAIT collects the RAM's registered read data.
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StRdWait = 1'b1
  } state_e;

endpackage

// File: rtl/tetris_soc_mem_arbiter_if.sv
// Bus bundle: two Avalon-style master ports plus the shared RAM port.
interface tetris_soc_mem_arbiter_if
  import tetris_soc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0]   m0_address,    m1_address;
  logic [DATA_W/8-1:0] m0_byteenable, m1_byteenable;
  logic                m0_read,       m1_read;
  logic                m0_write,      m1_write;
  logic [DATA_W-1:0]   m0_writedata,  m1_writedata;
  logic                m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0]   m0_readdata,   m1_readdata;
  logic                m0_readdatavalid, m1_readdatavalid;

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_chipselect;
  logic                mem_write;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  // Arbiter side.
  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  // Environment side: the two masters and the RAM.
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/tetris_rr_arbiter2.sv
// Two-way round-robin grant: on contention the master that did not win last time wins.
module tetris_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tetris_soc_mem_arbiter.sv
// Shares one single-port RAM between two masters; writes finish on acceptance,
// reads return two cycles after acceptance.
module tetris_soc_mem_arbiter
  import tetris_soc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                     clk,
  input logic                     reset,
  tetris_soc_mem_arbiter_if.slave bus
);

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   owner_q, owner_d;
  logic [NUM_MASTERS-1:0] req, grant;
  logic                   accept, sel, wr_sel, rd_return;
  logic [DATA_W-1:0]      rdata0_q, rdata1_q;
  logic                   rvalid0_q, rvalid1_q;

  // Read+write together counts as a request, and the write strobe decides the command.
  assign req    = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
  assign sel    = grant[1];
  assign wr_sel = sel ? bus.m1_write : bus.m0_write;
  // Reset gating keeps waitrequest high and the RAM idle while reset is held.
  assign accept = !reset && (state_q == StIdle) && (grant != '0);

  tetris_rr_arbiter2 u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    unique case (state_q)
      StRdWait: state_d = StIdle;
      default: begin
        if (accept) begin
          last_grant_d = sel;
          if (!wr_sel) begin
            state_d = StRdWait;
            owner_d = sel;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.mem_chipselect = accept;
    bus.mem_write      = accept & wr_sel;
    bus.mem_address    = '0;
    bus.mem_byteenable = '0;
    bus.mem_writedata  = '0;
    if (accept) begin
      bus.mem_address    = sel ? bus.m1_address    : bus.m0_address;
      bus.mem_byteenable = sel ? bus.m1_byteenable : bus.m0_byteenable;
      bus.mem_writedata  = sel ? bus.m1_writedata  : bus.m0_writedata;
    end
  end

  assign bus.mem_clken      = 1'b1;
  assign bus.m0_waitrequest = !(accept && !sel);
  assign bus.m1_waitrequest = !(accept && sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  // RAM data is valid during RD_WAIT; register it for the owner only.
  assign rd_return = (state_q == StRdWait);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= rd_return && !owner_q;
      rvalid1_q <= rd_return && owner_q;
      if (rd_return && !owner_q) rdata0_q <= bus.mem_readdata;
      if (rd_return && owner_q)  rdata1_q <= bus.mem_readdata;
    end
  end

  assign bus.m0_readdata      = rdata0_q;
  assign bus.m1_readdata      = rdata1_q;
  assign bus.m0_readdatavalid = rvalid0_q;
  assign bus.m1_readdatavalid = rvalid1_q;

endmodule
